// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshake bundle for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );
`else
  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller time-sharing one external full_adder, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output (ovf) and its c_msb_in flop.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_ca
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic             in_ready_q;
  logic             accept;
`ifdef SERIAL_ADD_OVF_EN
  logic             c_msb_in;
`endif

  // in_ready is registered so it stays low through reset and rises one edge after release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == IDLE);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    fa_a          = 1'b0;
    fa_b          = 1'b0;
    fa_c          = 1'b0;
    bus.in_ready  = in_ready_q;
    bus.out_valid = 1'b0;
    bus.result    = '0;
    bus.cout      = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    bus.ovf       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        fa_a = a_sh[0];
        fa_b = b_sh[0];
        fa_c = carry_q;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.result    = res_sh;
        bus.cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        bus.ovf       = c_msb_in ^ carry_q;
`endif
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inversion and forced carry happen once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry_q  <= 1'b0;
      bit_cnt  <= '0;
`ifdef SERIAL_ADD_OVF_EN
      c_msb_in <= 1'b0;
`endif
    end else if (accept) begin
      a_sh    <= bus.op_a;
      b_sh    <= bus.sub ? ~bus.op_b : bus.op_b;
      carry_q <= bus.sub | bus.cin;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      res_sh  <= {fa_s, res_sh[WIDTH-1:1]};
      carry_q <= fa_ca;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_ADD_OVF_EN
      // On the last bit carry_q still holds the carry into the MSB.
      if (bit_cnt == LAST_BIT) begin
        c_msb_in <= carry_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic/timeline reference model plus directed and random ops.
// Overflow checks are compiled in only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fa_a, fa_b, fa_c, fa_s, fa_ca;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int dut_ops  = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_c  (fa_c),
    .fa_s  (fa_s),
    .fa_ca (fa_ca)
  );

  // The attached full_adder cell.
  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_ca = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference arithmetic.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s,
                                 output logic [W-1:0] r, output logic co, output logic ov);
    logic [W-1:0] bi;
    int sum;
    bi  = s ? ~b : b;
    sum = int'(a) + int'(bi) + (s ? 1 : int'(ci));
    r   = W'(sum);
    co  = 1'((sum >> W) & 1);
    ov  = (a[W-1] == bi[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  // Timeline model: ready/busy flags and the accept cycle; outputs derive from elapsed cycles.
  bit           m_busy = 1'b0;
  bit           m_rdy  = 1'b0;
  int           cyc    = 0;
  int           m_acc  = 0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic         m_cin  = 1'b0;
  logic         m_sub  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rdy  = 1'b0;
    end else begin
      if (!m_busy) begin
        if (m_rdy && bus.in_valid) begin
          m_busy = 1'b1;
          m_rdy  = 1'b0;
          m_acc  = cyc + 1;
          m_a    = bus.op_a;
          m_b    = bus.op_b;
          m_cin  = bus.cin;
          m_sub  = bus.sub;
        end else begin
          m_rdy = 1'b1;
        end
      end else if ((cyc - m_acc) >= W && bus.out_ready) begin
        m_busy = 1'b0;
        m_rdy  = 1'b1;
      end
      cyc++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) dut_ops++;
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int k, msk, part;
    logic [W-1:0] bi, er;
    logic eco, eov;
    if (!rst_n) begin
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_cout", bus.cout, 0);
      check("rst_fa", {fa_a, fa_b, fa_c}, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", bus.ovf, 0);
`endif
    end else begin
      k = cyc - m_acc;
      check("in_ready", bus.in_ready, m_rdy);
      check("out_valid", bus.out_valid, (m_busy && k >= W));
      if (m_busy && k < W) begin
        bi   = m_sub ? ~m_b : m_b;
        msk  = (1 << k) - 1;
        part = (int'(m_a) & msk) + (int'(bi) & msk) + (m_sub ? 1 : int'(m_cin));
        check("fa_a", fa_a, m_a[k]);
        check("fa_b", fa_b, bi[k]);
        check("fa_c", fa_c, (part >> k) & 1);
      end else begin
        check("fa_idle", {fa_a, fa_b, fa_c}, 0);
      end
      if (m_busy && k >= W) begin
        ref_op(m_a, m_b, m_cin, m_sub, er, eco, eov);
        check("result", bus.result, er);
        check("cout", bus.cout, eco);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", bus.ovf, eov);
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s,
                       input int hold, input bit keep,
                       output logic [W-1:0] r, output logic co, output logic ov, output int lat);
    int n;
    @(negedge clk);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.cin       = ci;
    bus.sub       = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", bus.in_ready, 1);
    @(posedge clk);
    n_issued++;
    lat = 0;
    @(negedge clk);
    bus.in_valid = keep;
    while (!bus.out_valid && lat < 4 * W) begin
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.cin  = 1'($urandom);
      bus.sub  = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("out_valid_wait", bus.out_valid, 1);
    r  = bus.result;
    co = bus.cout;
`ifdef SERIAL_ADD_OVF_EN
    ov = bus.ovf;
`else
    ov = 1'b0;
`endif
    repeat (hold) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", {bus.cout, bus.result}, {co, r});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r, er, a, b;
    logic co, ov, eco, eov, ci, s;
    int lat, n;

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_after_release", bus.in_ready, 0);
    @(posedge clk);
    #1 check("ready_first_edge", bus.in_ready, 1);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat);
    check("t1_result", r, 8'h96);
    check("t1_cout", co, 0);
    check("t1_latency", lat, W);
`ifdef SERIAL_ADD_OVF_EN
    check("t1_ovf", ov, 1);
`endif

    do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1, 1'b0, r, co, ov, lat);
    check("t2_result", r, 8'h01);
    check("t2_cout", co, 1);
`ifdef SERIAL_ADD_OVF_EN
    check("t2_ovf", ov, 0);
`endif

    do_op(8'h10, 8'h20, 1'b1, 1'b1, 0, 1'b0, r, co, ov, lat);
    check("t3a_result", r, 8'hF0);
    check("t3a_cout", co, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("t3a_ovf", ov, 0);
`endif

    do_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0, r, co, ov, lat);
    check("t3b_result", r, 8'h7F);
    check("t3b_cout", co, 1);
    check("t3b_latency", lat, W);
`ifdef SERIAL_ADD_OVF_EN
    check("t3b_ovf", ov, 1);
`endif

    do_op(8'h33, 8'h44, 1'b0, 1'b0, 5, 1'b1, r, co, ov, lat);
    check("t4_result", r, 8'h77);
    check("t4_cout", co, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    bus.op_a     = 8'hC3;
    bus.op_b     = 8'h5A;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_accept_wait", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_result", bus.result, 0);
    check("t6_cout", bus.cout, 0);
    check("t6_fa", {fa_a, fa_b, fa_c}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat);
    check("t6_after_result", r, 8'h02);
    check("t6_after_cout", co, 0);

    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      s  = 1'($urandom);
      ref_op(a, b, ci, s, er, eco, eov);
      do_op(a, b, ci, s, $urandom_range(0, 3), 1'($urandom), r, co, ov, lat);
      check("rnd_result", r, er);
      check("rnd_cout", co, eco);
      check("rnd_latency", lat, W);
`ifdef SERIAL_ADD_OVF_EN
      check("rnd_ovf", ov, eov);
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("op_count", dut_ops, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
